load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_pkg.sv | 50 +++++
 rtl/load_store_unit_align.sv | 55 +++++
 rtl/load_store_unit.sv | 160 ++++++++++++++++
 tb/tb_load_store_unit.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit.
//   lsu_state_e   : FSM state encoding (IDLE / BUSY / DONE)
//   F3_*          : RV32 funct3 size/sign codes for loads and stores
//   ERR_*         : err_code_o encodings
//   f3_legal()    : funct3 legality for the given op direction
//   misaligned()  : natural-alignment check for the access size
package load_store_unit_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } lsu_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_FUNCT3   = 2'b10;

  function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
    logic ok;
    if (is_store)
      ok = (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    else
      ok = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
    return ok;
  endfunction

  // funct3[1:0] carries the access size: 00 byte, 01 half, 10 word.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    logic mis;
    case (f3[1:0])
      2'b01:   mis = addr_lo[0];
      2'b10:   mis = (addr_lo != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// lsu_align: purely combinational lane logic for the load/store unit.
//   funct3    in  3     size/sign code
//   addr_lo   in  2     byte offset within the word
//   wdata     in  WIDTH raw store data (rs2)
//   rdata     in  WIDTH raw memory read word
//   be        out 4     byte enables for the access size and offset
//   wdata_rep out WIDTH store data replicated across all lanes of its size
//   load_data out WIDTH selected lane, sign- or zero-extended
module lsu_align #(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       funct3,
  input  logic [1:0]       addr_lo,
  input  logic [WIDTH-1:0] wdata,
  input  logic [WIDTH-1:0] rdata,
  output logic [3:0]       be,
  output logic [WIDTH-1:0] wdata_rep,
  output logic [WIDTH-1:0] load_data
);
  import load_store_unit_pkg::*;

  logic [WIDTH-1:0] shifted;

  always_comb begin
    be        = 4'b1111;
    wdata_rep = wdata;
    load_data = '0;
    // Bring the addressed lane down to bit 0 before extending.
    shifted   = rdata >> {addr_lo, 3'b000};

    case (funct3[1:0])
      2'b00: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {(WIDTH/8){wdata[7:0]}};
      end
      2'b01: begin
        be        = 4'b0011 << addr_lo;
        wdata_rep = {(WIDTH/16){wdata[15:0]}};
      end
      default: begin
        be        = 4'b1111;
        wdata_rep = wdata;
      end
    endcase

    case (funct3)
      F3_LB:   load_data = {{(WIDTH-8){shifted[7]}}, shifted[7:0]};
      F3_LH:   load_data = {{(WIDTH-16){shifted[15]}}, shifted[15:0]};
      F3_LBU:  load_data = {{(WIDTH-8){1'b0}}, shifted[7:0]};
      F3_LHU:  load_data = {{(WIDTH-16){1'b0}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage data-memory sequencer.
// Accepts one load/store from EX, issues a single request to data memory,
// waits for the ack, formats the load result and pulses done_o.
// Illegal funct3 or misaligned addresses are rejected with an err_o pulse.
//   clk, reset        clock, synchronous active-high reset
//   ex_valid_i        EX result valid
//   mem_rd_i/mem_wr_i load/store op (both high = store)
//   funct3_i          size/sign code
//   addr_i, wdata_i   effective address, store data
//   dmem_*            memory request interface (registered)
//   stall_o           freeze IF/ID/EX (combinational)
//   done_o            access complete pulse
//   load_data_o       formatted load result
//   err_o, err_code_o fault pulse and code (01 misaligned, 10 bad funct3)
module load_store_unit #(
  parameter int WIDTH    = 32,
  parameter int ADDR_LEN = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ex_valid_i,
  input  logic                mem_rd_i,
  input  logic                mem_wr_i,
  input  logic [2:0]          funct3_i,
  input  logic [ADDR_LEN-1:0] addr_i,
  input  logic [WIDTH-1:0]    wdata_i,
  output logic                dmem_req_o,
  output logic                dmem_we_o,
  output logic [ADDR_LEN-1:0] dmem_addr_o,
  output logic [WIDTH-1:0]    dmem_wdata_o,
  output logic [3:0]          dmem_be_o,
  input  logic                dmem_ack_i,
  input  logic [WIDTH-1:0]    dmem_rdata_i,
  output logic                stall_o,
  output logic                done_o,
  output logic [WIDTH-1:0]    load_data_o,
  output logic                err_o,
  output logic [1:0]          err_code_o
);
  import load_store_unit_pkg::*;

  lsu_state_e state, state_next;

  logic       accept;
  logic       is_store;
  logic       f3_ok;
  logic       mis;
  logic       legal;

  logic       op_store_q;
  logic [2:0] funct3_q;
  logic [1:0] addr_lo_q;

  logic [2:0]       al_funct3;
  logic [1:0]       al_addr_lo;
  logic [3:0]       al_be;
  logic [WIDTH-1:0] al_wdata;
  logic [WIDTH-1:0] al_load;

  always_comb begin
    accept   = (state == S_IDLE) && ex_valid_i && (mem_rd_i || mem_wr_i);
    is_store = mem_wr_i;
    f3_ok    = f3_legal(funct3_i, is_store);
    mis      = misaligned(funct3_i, addr_i[1:0]);
    legal    = f3_ok && !mis;
    stall_o  = (accept && legal) || (state == S_BUSY);
  end

  // One shared aligner: in IDLE it builds be/wdata from the incoming op,
  // in BUSY it extracts the load lane using the latched size and offset.
  always_comb begin
    if (state == S_BUSY) begin
      al_funct3  = funct3_q;
      al_addr_lo = addr_lo_q;
    end else begin
      al_funct3  = funct3_i;
      al_addr_lo = addr_i[1:0];
    end
  end

  lsu_align #(
    .WIDTH (WIDTH)
  ) u_align (
    .funct3    (al_funct3),
    .addr_lo   (al_addr_lo),
    .wdata     (wdata_i),
    .rdata     (dmem_rdata_i),
    .be        (al_be),
    .wdata_rep (al_wdata),
    .load_data (al_load)
  );

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (accept && legal) state_next = S_BUSY;
      S_BUSY:  if (dmem_ack_i)      state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dmem_req_o   <= 1'b0;
      dmem_we_o    <= 1'b0;
      dmem_addr_o  <= '0;
      dmem_wdata_o <= '0;
      dmem_be_o    <= '0;
      done_o       <= 1'b0;
      load_data_o  <= '0;
      err_o        <= 1'b0;
      err_code_o   <= ERR_NONE;
      op_store_q   <= 1'b0;
      funct3_q     <= '0;
      addr_lo_q    <= '0;
    end else begin
      done_o     <= 1'b0;
      err_o      <= 1'b0;
      err_code_o <= ERR_NONE;
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_store_q <= is_store;
            funct3_q   <= funct3_i;
            addr_lo_q  <= addr_i[1:0];
            if (legal) begin
              dmem_req_o   <= 1'b1;
              dmem_we_o    <= is_store;
              dmem_addr_o  <= {addr_i[ADDR_LEN-1:2], 2'b00};
              dmem_wdata_o <= al_wdata;
              dmem_be_o    <= al_be;
            end else begin
              err_o      <= 1'b1;
              err_code_o <= f3_ok ? ERR_MISALIGN : ERR_FUNCT3;
            end
          end
        end
        S_BUSY: begin
          if (dmem_ack_i) begin
            dmem_req_o <= 1'b0;
            dmem_we_o  <= 1'b0;
            done_o     <= 1'b1;
            if (!op_store_q)
              load_data_o <= al_load;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid_i;
  logic        mem_rd_i;
  logic        mem_wr_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [31:0] dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_ack_i;
  logic [31:0] dmem_rdata_i;
  logic        stall_o;
  logic        done_o;
  logic [31:0] load_data_o;
  logic        err_o;
  logic [1:0]  err_code_o;

  load_store_unit #(
    .WIDTH    (32),
    .ADDR_LEN (32)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ex_valid_i   (ex_valid_i),
    .mem_rd_i     (mem_rd_i),
    .mem_wr_i     (mem_wr_i),
    .funct3_i     (funct3_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .dmem_req_o   (dmem_req_o),
    .dmem_we_o    (dmem_we_o),
    .dmem_addr_o  (dmem_addr_o),
    .dmem_wdata_o (dmem_wdata_o),
    .dmem_be_o    (dmem_be_o),
    .dmem_ack_i   (dmem_ack_i),
    .dmem_rdata_i (dmem_rdata_i),
    .stall_o      (stall_o),
    .done_o       (done_o),
    .load_data_o  (load_data_o),
    .err_o        (err_o),
    .err_code_o   (err_code_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_err;
    logic [1:0]  code;
    logic [31:0] ldata;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] addr;
    logic        we;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;
  int   done_count = 0;
  int   stall_cycles = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: snapshot the request when it appears, check it stays stable,
  // and pop the scoreboard on every done_o / err_o.
  logic        prev_req = 1'b0;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_be;
  logic        s_we;

  always @(negedge clk) begin
    exp_t e;
    if (stall_o) stall_cycles++;
    if (!reset) begin
      if (dmem_req_o && prev_req) begin
        chk("hold_addr",  dmem_addr_o,  s_addr);
        chk("hold_be",    {28'd0, dmem_be_o}, {28'd0, s_be});
        chk("hold_wdata", dmem_wdata_o, s_wdata);
        chk("hold_we",    {31'd0, dmem_we_o}, {31'd0, s_we});
      end
      if (dmem_req_o && !prev_req) begin
        s_addr  = dmem_addr_o;
        s_be    = dmem_be_o;
        s_wdata = dmem_wdata_o;
        s_we    = dmem_we_o;
      end
    end
    prev_req = dmem_req_o;

    if (done_o && err_o) begin
      checks++; errors++;
      $display("FAIL done_err_same_cycle: got done_o=1 err_o=1 required not both");
    end
    if (done_o) begin
      done_count++;
      if (sbq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: got done_o=1 required no completion");
      end else begin
        e = sbq.pop_front();
        if (e.is_err) begin
          checks++; errors++;
          $display("FAIL event_kind: got done_o required err_o code %0d", e.code);
        end else begin
          chk("req_addr",  s_addr,  e.addr);
          chk("req_be",    {28'd0, s_be}, {28'd0, e.be});
          chk("req_wdata", s_wdata, e.wdata);
          chk("req_we",    {31'd0, s_we}, {31'd0, e.we});
          chk("load_data", load_data_o, e.ldata);
        end
      end
    end
    if (err_o) begin
      if (sbq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_err: got err_o=1 code %0d required none", err_code_o);
      end else begin
        e = sbq.pop_front();
        if (!e.is_err) begin
          checks++; errors++;
          $display("FAIL event_kind: got err_o code %0d required done_o", err_code_o);
        end else begin
          chk("err_code", {30'd0, err_code_o}, {30'd0, e.code});
        end
      end
    end
  end

  function automatic exp_t mk(input bit is_err, input logic [1:0] code,
                              input logic [31:0] ldata, input logic [3:0] be,
                              input logic [31:0] wdata, input logic [31:0] addr,
                              input logic we);
    exp_t e;
    e.is_err = is_err; e.code = code; e.ldata = ldata; e.be = be;
    e.wdata = wdata; e.addr = addr; e.we = we;
    return e;
  endfunction

  // Legal access: accept, ack after ack_dly BUSY cycles, end in the DONE cycle.
  task automatic access(input string name, input bit rd, input bit wr,
                        input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int ack_dly,
                        input logic [31:0] rdata, input exp_t e);
    @(posedge clk); #1;
    ex_valid_i = 1'b1; mem_rd_i = rd; mem_wr_i = wr;
    funct3_i = f3; addr_i = a; wdata_i = wd;
    sbq.push_back(e);
    #1 chk({name, "_accept_stall"}, {31'd0, stall_o}, 32'd1);
    @(posedge clk); #1;
    ex_valid_i = 1'b0; mem_rd_i = 1'b0; mem_wr_i = 1'b0;
    repeat (ack_dly - 1) @(posedge clk);
    if (ack_dly > 1) #1;
    dmem_ack_i = 1'b1; dmem_rdata_i = rdata;
    @(posedge clk); #1;
    dmem_ack_i = 1'b0; dmem_rdata_i = 32'h5A5A_5A5A;
    chk({name, "_done_latency"}, {31'd0, done_o}, 32'd1);
    chk({name, "_done_stall"}, {31'd0, stall_o}, 32'd0);
  endtask

  // Illegal access: expect no request and an err_o pulse in the next cycle.
  task automatic bad_access(input string name, input bit rd, input bit wr,
                            input logic [2:0] f3, input logic [31:0] a,
                            input logic [1:0] code);
    @(posedge clk); #1;
    stall_cycles = 0;
    ex_valid_i = 1'b1; mem_rd_i = rd; mem_wr_i = wr;
    funct3_i = f3; addr_i = a; wdata_i = 32'h1111_2222;
    sbq.push_back(mk(1'b1, code, 32'd0, 4'd0, 32'd0, 32'd0, 1'b0));
    @(posedge clk); #1;
    ex_valid_i = 1'b0; mem_rd_i = 1'b0; mem_wr_i = 1'b0;
    chk({name, "_no_req"}, {31'd0, dmem_req_o}, 32'd0);
    chk({name, "_err_pulse"}, {31'd0, err_o}, 32'd1);
    @(posedge clk); #1;
    chk({name, "_no_stall"}, stall_cycles, 32'd0);
  endtask

  initial begin
    int dc;
    reset = 1'b1; ex_valid_i = 1'b0; mem_rd_i = 1'b0; mem_wr_i = 1'b0;
    funct3_i = 3'd0; addr_i = 32'd0; wdata_i = 32'd0;
    dmem_ack_i = 1'b0; dmem_rdata_i = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req",   {31'd0, dmem_req_o}, 32'd0);
    chk("rst_stall", {31'd0, stall_o}, 32'd0);
    chk("rst_ldata", load_data_o, 32'd0);
    chk("rst_err",   {29'd0, err_o, err_code_o}, 32'd0);
    chk("rst_done",  {31'd0, done_o}, 32'd0);
    chk("rst_be",    {28'd0, dmem_be_o}, 32'd0);
    reset = 1'b0;

    // Loads
    access("lw100", 1, 0, 3'b010, 32'h100, 32'h0, 1, 32'hDEADBEEF,
           mk(0, 2'b00, 32'hDEADBEEF, 4'b1111, 32'h0, 32'h100, 0));
    access("lb103", 1, 0, 3'b000, 32'h103, 32'h0, 2, 32'h80FF_0000,
           mk(0, 2'b00, 32'hFFFF_FF80, 4'b1000, 32'h0, 32'h100, 0));
    access("lbu103", 1, 0, 3'b100, 32'h103, 32'h0, 1, 32'h80FF_0000,
           mk(0, 2'b00, 32'h0000_0080, 4'b1000, 32'h0, 32'h100, 0));
    access("lh102", 1, 0, 3'b001, 32'h102, 32'h0, 1, 32'h8001_0000,
           mk(0, 2'b00, 32'hFFFF_8001, 4'b1100, 32'h0, 32'h100, 0));
    access("lhu102", 1, 0, 3'b101, 32'h102, 32'h0, 1, 32'h8001_0000,
           mk(0, 2'b00, 32'h0000_8001, 4'b1100, 32'h0, 32'h100, 0));

    // Stores leave load_data_o unchanged (still 0x00008001)
    stall_cycles = 0;
    access("sh102", 0, 1, 3'b001, 32'h102, 32'h1234_ABCD, 4, 32'hFFFF_FFFF,
           mk(0, 2'b00, 32'h0000_8001, 4'b1100, 32'hABCD_ABCD, 32'h100, 1));
    @(negedge clk); #1;
    chk("sh102_stall_cycles", stall_cycles, 32'd5);
    access("sb101", 0, 1, 3'b000, 32'h101, 32'h0000_00A5, 3, 32'h0,
           mk(0, 2'b00, 32'h0000_8001, 4'b0010, 32'hA5A5_A5A5, 32'h100, 1));

    // Faults; funct3 error wins over misalignment
    bad_access("lw101",   1, 0, 3'b010, 32'h101, 2'b01);
    bad_access("lh103",   1, 0, 3'b001, 32'h103, 2'b01);
    bad_access("ld011",   1, 0, 3'b011, 32'h100, 2'b10);
    bad_access("s100mis", 0, 1, 3'b100, 32'h101, 2'b10);

    // Reset in BUSY, then a late ack
    @(posedge clk); #1;
    ex_valid_i = 1'b1; mem_rd_i = 1'b1; mem_wr_i = 1'b0;
    funct3_i = 3'b010; addr_i = 32'h200;
    @(posedge clk); #1;
    ex_valid_i = 1'b0; mem_rd_i = 1'b0;
    chk("rb_busy_req", {31'd0, dmem_req_o}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rb_req_low",  {31'd0, dmem_req_o}, 32'd0);
    chk("rb_ldata",    load_data_o, 32'd0);
    chk("rb_stall",    {31'd0, stall_o}, 32'd0);
    dc = done_count;
    dmem_ack_i = 1'b1; dmem_rdata_i = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    dmem_ack_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rb_no_done", done_count, dc);
    chk("rb_ldata_after_ack", load_data_o, 32'd0);

    // Spurious ack in IDLE
    dc = done_count;
    dmem_ack_i = 1'b1; dmem_rdata_i = 32'h1357_9BDF;
    @(posedge clk); #1;
    dmem_ack_i = 1'b0;
    @(posedge clk); #1;
    chk("spur_no_done", done_count, dc);
    chk("spur_no_req",  {31'd0, dmem_req_o}, 32'd0);
    chk("spur_ldata",   load_data_o, 32'd0);

    // Back-to-back: rd&wr both high is a store; LW accepted right after DONE
    access("sw204", 1, 1, 3'b010, 32'h204, 32'hCAFE_F00D, 1, 32'h0,
           mk(0, 2'b00, 32'h0, 4'b1111, 32'hCAFE_F00D, 32'h204, 1));
    access("lw204", 1, 0, 3'b010, 32'h204, 32'h0, 1, 32'h0123_4567,
           mk(0, 2'b00, 32'h0123_4567, 4'b1111, 32'h0, 32'h204, 0));

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", sbq.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1);
  end

endmodule
